// File: rtl/wallace_mac_acc.sv
// wallace_mac_acc
// ---------------
// Accumulates a programmed number of 16-bit unsigned products from the
// Wallace-tree multiplier. It presents the final sum on an output handshake.
//
// Optional build macro: WALLACE_MAC_SAT_EN
//   defined   : on carry-out the accumulator saturates to all-ones and stays
//               there for the rest of the run. ovf still sets.
//   undefined : the accumulator wraps modulo 2^ACC_W. ovf sets on any
//               carry-out.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   start      : begin a new accumulation (honoured only in IDLE)
//   len        : number of products to sum, sampled when start is accepted
//   abort      : cancel the current accumulation (ACCUM or DONE)
//   prod_in    : 16-bit unsigned product
//   prod_valid : prod_in is valid
//   prod_ready : block accepts prod_in (high only in ACCUM)
//   acc_out    : accumulator value, meaningful while acc_valid = 1
//   acc_valid  : final sum available (high only in DONE)
//   acc_ready  : consumer accepts acc_out
//   busy       : high in ACCUM and DONE
//   ovf        : sticky overflow flag for the current accumulation
//   dbg_state  : current FSM state (0 = IDLE, 1 = ACCUM, 2 = DONE)
//
// Handshake semantics:
//   - A transfer happens on a rising edge where both valid and ready are 1.
//   - A valid side keeps its data stable until the transfer.
//   - Ready and valid outputs are decoded from the registered state only.
//     Neither depends combinationally on the partner's signal.
module wallace_mac_acc #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    input  logic [15:0]      prod_in,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             busy,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CNT_W-1:0]   len_q, len_nxt;
    logic               ovf_q, ovf_nxt;

    logic [SUM_W-1:0]   sum;
    logic [ACC_W-1:0]   acc_add;
    logic               last;

    // The sum is one bit wider than the accumulator so that the carry-out is
    // observable.
    assign sum  = {1'b0, acc} + SUM_W'(prod_in);
    assign last = (cnt == (len_q - CNT_W'(1)));

`ifdef WALLACE_MAC_SAT_EN
    // Once ovf is set, the accumulator is pinned at all-ones for the rest of
    // the run, including for zero-valued products.
    assign acc_add = (sum[ACC_W] || ovf_q) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_add = sum[ACC_W-1:0];
`endif

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        len_nxt   = len_q;
        ovf_nxt   = ovf_q;
        case (state)
            S_IDLE: begin
                // abort has no effect here, so start wins when both are high.
                if (start) begin
                    len_nxt   = len;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    state_nxt = (len != '0) ? S_ACCUM : S_DONE;
                end
            end
            S_ACCUM: begin
                if (abort) begin
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    state_nxt = S_IDLE;
                end else if (prod_valid) begin
                    // prod_ready is 1 throughout ACCUM, so prod_valid alone
                    // marks a transfer.
                    acc_nxt = acc_add;
                    cnt_nxt = cnt + CNT_W'(1);
                    if (sum[ACC_W]) begin
                        ovf_nxt = 1'b1;
                    end
                    if (last) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (abort) begin
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    state_nxt = S_IDLE;
                end else if (acc_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            len_q <= len_nxt;
            ovf_q <= ovf_nxt;
        end
    end

    assign prod_ready = (state == S_ACCUM);
    assign acc_valid  = (state == S_DONE);
    assign busy       = (state != S_IDLE);
    assign acc_out    = acc;
    assign ovf        = ovf_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_wallace_mac_acc.sv
// Bench for wallace_mac_acc.
// Two instances (ACC_W = 24 and ACC_W = 16) share every input. Because
// handshake timing does not depend on width, one stimulus stream exercises
// both widths. Expected sums come from plain integer arithmetic on the list of
// products in each job.
module tb_wallace_mac_acc;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             abort;
    logic [15:0]      prod_in;
    logic             prod_valid;
    logic             acc_ready;

    logic             pr24, av24, busy24, ovf24;
    logic [23:0]      ao24;
    logic [1:0]       st24;
    logic             pr16, av16, busy16, ovf16;
    logic [15:0]      ao16;
    logic [1:0]       st16;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [24:0] exp24_q[$];   // {ovf, acc_out}
    logic [16:0] exp16_q[$];
    logic [15:0] job_q[$];     // products for the next job

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    wallace_mac_acc #(.ACC_W(24), .CNT_W(CNT_W)) dut24 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
        .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(pr24),
        .acc_out(ao24), .acc_valid(av24), .acc_ready(acc_ready),
        .busy(busy24), .ovf(ovf24), .dbg_state(st24)
    );

    wallace_mac_acc #(.ACC_W(16), .CNT_W(CNT_W)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
        .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(pr16),
        .acc_out(ao16), .acc_valid(av16), .acc_ready(acc_ready),
        .busy(busy16), .ovf(ovf16), .dbg_state(st16)
    );

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the true sum of the products, reduced to w bits by the overflow policy.
    function automatic logic [32:0] model(input longint s, input int w);
        longint     lim;
        logic       o;
        logic [31:0] a;
        lim = longint'(1) << w;
        o   = (s >= lim);
`ifdef WALLACE_MAC_SAT_EN
        a = o ? 32'(lim - 1) : 32'(s);
`else
        a = 32'(s % lim);
`endif
        return {o, a};
    endfunction

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (rst_n && av24) begin
            if (exp24_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_valid24: got acc_valid=1 expected 0 (t=%0t)", $time);
            end else begin
                check("result24", {8'd0, ovf24, ao24}, {8'd0, exp24_q[0]});
                if (acc_ready) void'(exp24_q.pop_front());
            end
            check("prod_ready_in_done24", {32'd0, pr24}, 33'd0);
        end
    end

    always @(negedge clk) begin
        if (rst_n && av16) begin
            if (exp16_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_valid16: got acc_valid=1 expected 0 (t=%0t)", $time);
            end else begin
                check("result16", {16'd0, ovf16, ao16}, {16'd0, exp16_q[0]});
                if (acc_ready) void'(exp16_q.pop_front());
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_prod_ready"}, {32'd0, pr24 | pr16}, 33'd0);
        check({tag, "_acc_valid"},  {32'd0, av24 | av16}, 33'd0);
        check({tag, "_busy"},       {32'd0, busy24 | busy16}, 33'd0);
        check({tag, "_ovf"},        {32'd0, ovf24 | ovf16}, 33'd0);
        check({tag, "_acc_out24"},  {9'd0, ao24}, 33'd0);
        check({tag, "_acc_out16"},  {17'd0, ao16}, 33'd0);
    endtask

    // ---------------- driver ----------------
    // cut_mode: 0 = complete run, 1 = abort after 2 products, 2 = reset after 2 products.
    // Entered and left at #1 after a rising edge.
    task automatic run_job(input int gap_min, input int gap_max, input int rdelay,
                           input int cut_mode, input bit extra_start);
        int          n;
        longint      s;
        logic [32:0] r;
        bit          hs;
        int          t;
        n = job_q.size();
        s = 0;
        foreach (job_q[i]) s += longint'(job_q[i]);
        if (cut_mode == 0) begin
            r = model(s, 24); exp24_q.push_back({r[32], r[23:0]});
            r = model(s, 16); exp16_q.push_back({r[32], r[15:0]});
        end
        start = 1'b1; len = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0; len = '0;
        for (int i = 0; i < n; i++) begin
            if (cut_mode != 0 && i == 2) break;
            prod_valid = 1'b0;
            repeat ($urandom_range(gap_max, gap_min)) begin @(posedge clk); #1; end
            prod_valid = 1'b1;
            prod_in    = job_q[i];
            if (extra_start && i == 1) begin start = 1'b1; len = CNT_W'(9); end
            t = 0;
            do begin
                @(negedge clk); hs = pr24;
                @(posedge clk); #1;
                start = 1'b0; len = '0;
                t++;
            end while (!hs && t < 100);
            if (!hs) begin
                n_cmp++; n_fail++;
                $display("FAIL prod_handshake_timeout: got prod_ready=0 expected 1 within 100 cycles");
            end
            prod_valid = 1'b0;
        end
        if (cut_mode == 1) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            @(negedge clk);
            check("abort_busy",  {32'd0, busy24 | busy16}, 33'd0);
            check("abort_valid", {32'd0, av24 | av16}, 33'd0);
            check("abort_ovf",   {32'd0, ovf24 | ovf16}, 33'd0);
            @(posedge clk); #1;
        end else if (cut_mode == 2) begin
            rst_n = 1'b0;
            @(posedge clk); #1;
            @(negedge clk);
            check_all_zero("midrun_reset");
            @(posedge clk); #1;
            rst_n = 1'b1;
        end else begin
            // The sum is visible one cycle after the last handshake; for len=0 it
            // is visible one cycle after start.
            check("latency_valid24", {32'd0, av24}, 33'd1);
            check("latency_valid16", {32'd0, av16}, 33'd1);
            repeat (rdelay) begin @(posedge clk); #1; end
            acc_ready = 1'b1;
            @(posedge clk); #1;
            acc_ready = 1'b0;
            @(negedge clk);
            check("idle_after_ready", {31'd0, busy24, av24}, 33'd0);
            @(posedge clk); #1;
        end
        job_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
        prod_in = '0; prod_valid = 1'b0; acc_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic sum: 3 x 0xFE01 = 0x02FA03.
        job_q = '{16'hFE01, 16'hFE01, 16'hFE01};
        run_job(0, 0, 0, 0, 1'b0);

        // Backpressure on both sides.
        job_q = '{16'h0010, 16'h0020};
        run_job(3, 3, 4, 0, 1'b0);

        // Zero length.
        run_job(0, 0, 2, 0, 1'b0);

        // Overflow in the 16-bit instance.
        job_q = '{16'hFE01, 16'hFE01};
        run_job(0, 1, 1, 0, 1'b0);

        // Abort mid-run, then a fresh len=1 run.
        job_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        run_job(0, 1, 0, 1, 1'b0);
        job_q = '{16'h0005};
        run_job(0, 0, 0, 0, 1'b0);

        // Reset mid-run, then the same fresh run.
        job_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        run_job(0, 1, 0, 2, 1'b0);
        job_q = '{16'h0005};
        run_job(0, 0, 0, 0, 1'b0);

        // start with len=9 during a len=2 run is ignored.
        job_q = '{16'(($urandom & 16'hFFFF)), 16'(($urandom & 16'hFFFF))};
        run_job(0, 2, 1, 0, 1'b1);

        // Randomised runs; large products drive the 16-bit instance into overflow.
        for (int j = 0; j < 40; j++) begin
            int n;
            n = $urandom_range(12, 0);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(1, 0) == 1)
                    job_q.push_back(16'(($urandom & 16'h00FF) | 16'hFF00));
                else
                    job_q.push_back(16'(($urandom & 16'hFFFF)));
            end
            run_job(0, $urandom_range(3, 0), $urandom_range(3, 0), 0, 1'b0);
        end

        repeat (3) @(posedge clk);
        check("queue24_drained", 33'(exp24_q.size()), 33'd0);
        check("queue16_drained", 33'(exp16_q.size()), 33'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
